// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, exception codes, FSM state encoding
// and the default exception vector.
package cp0_pkg;

   localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
   localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;
   localparam logic [4:0] CP0_ADDR_COUNT  = 5'd22;

   localparam logic [4:0] EXC_CODE_OV = 5'd12;
   localparam logic [4:0] EXC_CODE_RI = 5'd10;

   localparam logic [31:0] CP0_DEFAULT_VECTOR = 32'h8000_0180;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_RETURN   = 2'd2
   } cp0_state_e;

   function automatic logic [31:0] cause_word(input logic [4:0] code);
      return {25'b0, code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_exc_counter.sv
// Exception event counter; only present in builds with CP0_EXC_COUNT_EN defined.
module cp0_exc_counter
   import cp0_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        inc_i,
   input  logic        wr_en_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] count_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   // Hardware increment wins over a colliding mtc0 write; wraps naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         cnt_d = cnt_q + 32'd1;
      end else if (wr_en_i) begin
         cnt_d = wr_data_i;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/cp0_exc_regs.sv
// CP0 exception registers (Status/Cause/EPC) with redirect FSM.
// Optional exception counter at address 22 enabled by CP0_EXC_COUNT_EN.
module cp0_exc_regs
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = CP0_DEFAULT_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_valid,
   input  logic        exc_cause,
   input  logic [31:0] exc_epc,
   input  logic        eret,
   input  logic        mtc0_en,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_data,
   input  logic [4:0]  mfc0_addr,
   output logic [31:0] mfc0_data,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic        exl
);

   cp0_state_e  state_q;
   cp0_state_e  state_d;
   logic [31:0] epc_q;
   logic [31:0] epc_d;
   logic [4:0]  code_q;
   logic [4:0]  code_d;
   logic [1:0]  status_q;
   logic [1:0]  status_d;
   logic        pc_redirect_q;
   logic        pc_redirect_d;
   logic [31:0] redirect_pc_q;
   logic [31:0] redirect_pc_d;
   logic [31:0] count_s;

   logic        exc_take_s;
   logic        eret_take_s;
   logic        wr_status_s;
   logic        wr_epc_s;
   logic        wr_count_s;

   // Events are only accepted in RUN; REDIRECT/RETURN are flush cycles.
   always_comb begin
      exc_take_s  = (state_q == ST_RUN) && exc_valid;
      eret_take_s = (state_q == ST_RUN) && !exc_valid && eret && status_q[1];
      wr_status_s = mtc0_en && (mtc0_addr == CP0_ADDR_STATUS);
      wr_epc_s    = mtc0_en && (mtc0_addr == CP0_ADDR_EPC);
      wr_count_s  = mtc0_en && (mtc0_addr == CP0_ADDR_COUNT);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = ST_RUN;
      case (state_q)
         ST_RUN: begin
            if (exc_take_s) begin
               state_d = ST_REDIRECT;
            end else if (eret_take_s) begin
               state_d = ST_RETURN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_REDIRECT: state_d = ST_RUN;
         ST_RETURN:   state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   // CP0 register next values; a hardware update drops a colliding mtc0 write.
   always_comb begin
      epc_d    = epc_q;
      code_d   = code_q;
      status_d = status_q;
      if (exc_take_s) begin
         code_d      = exc_cause ? EXC_CODE_OV : EXC_CODE_RI;
         status_d[1] = 1'b1;
         if (!status_q[1]) begin
            epc_d = exc_epc;
         end else if (wr_epc_s) begin
            epc_d = mtc0_data;
         end else begin
            epc_d = epc_q;
         end
      end else if (eret_take_s) begin
         status_d[1] = 1'b0;
         if (wr_epc_s) begin
            epc_d = mtc0_data;
         end else begin
            epc_d = epc_q;
         end
      end else begin
         if (wr_status_s) begin
            status_d = mtc0_data[1:0];
         end else begin
            status_d = status_q;
         end
         if (wr_epc_s) begin
            epc_d = mtc0_data;
         end else begin
            epc_d = epc_q;
         end
      end
   end

   // CP0 register storage.
   always_ff @(posedge clk) begin
      if (!reset) begin
         epc_q    <= 32'd0;
         code_q   <= 5'd0;
         status_q <= 2'b00;
      end else begin
         epc_q    <= epc_d;
         code_q   <= code_d;
         status_q <= status_d;
      end
   end

   // Output decode from the next state so the pulse appears with the state.
   always_comb begin
      pc_redirect_d = 1'b0;
      redirect_pc_d = 32'd0;
      case (state_d)
         ST_REDIRECT: begin
            pc_redirect_d = 1'b1;
            redirect_pc_d = EXC_VECTOR;
         end
         ST_RETURN: begin
            pc_redirect_d = 1'b1;
            redirect_pc_d = epc_d;
         end
         default: begin
            pc_redirect_d = 1'b0;
            redirect_pc_d = 32'd0;
         end
      endcase
   end

   // Registered redirect outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_redirect_q <= 1'b0;
         redirect_pc_q <= 32'd0;
      end else begin
         pc_redirect_q <= pc_redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

`ifdef CP0_EXC_COUNT_EN
   cp0_exc_counter u_counter (
      .clk_i     (clk),
      .reset_i   (reset),
      .inc_i     (exc_take_s),
      .wr_en_i   (wr_count_s),
      .wr_data_i (mtc0_data),
      .count_o   (count_s)
   );
`else
   logic unused_count_s;
   assign unused_count_s = wr_count_s;
   assign count_s = 32'd0;
`endif

   // Combinational mfc0 read mux.
   always_comb begin
      mfc0_data = 32'd0;
      case (mfc0_addr)
         CP0_ADDR_STATUS: mfc0_data = {30'd0, status_q};
         CP0_ADDR_CAUSE:  mfc0_data = cause_word(code_q);
         CP0_ADDR_EPC:    mfc0_data = epc_q;
         CP0_ADDR_COUNT:  mfc0_data = count_s;
         default:         mfc0_data = 32'd0;
      endcase
   end

   assign pc_redirect = pc_redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign exl         = status_q[1];

endmodule

// File: doc/cp0_exc_regs.md
CP0_EXC_REGS -- requirements
Module: cp0_exc_regs

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, exception handler entry address.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port exc_valid, input, 1: exception request, driven by the exception unit's ChooseEPC.
REQ-005 SHALL have port exc_cause, input, 1: 1 = arithmetic overflow, 0 = undefined instruction.
REQ-006 SHALL have port exc_epc, input, 32: address of the faulting instruction.
REQ-007 SHALL have port eret, input, 1: ERET executing.
REQ-008 SHALL have ports mtc0_en (input, 1), mtc0_addr (input, 5) and mtc0_data (input, 32): CP0 register write.
REQ-009 SHALL have ports mfc0_addr (input, 5) and mfc0_data (output, 32): combinational CP0 register read.
REQ-010 SHALL have ports pc_redirect (output, 1), redirect_pc (output, 32) and exl (output, 1): fetch redirect and exception-level flag.

Function
REQ-011 SHALL implement three states: RUN, REDIRECT and RETURN; HANDLER is RUN with exl=1.
REQ-012 SHALL, in RUN with exl=0 and exc_valid=1: latch EPC<=exc_epc, set ExcCode, set exl<=1, and enter REDIRECT at the next edge.
REQ-013 SHALL encode the Cause register as {25'b0, ExcCode[4:0], 2'b00}, with overflow = 12 (Cause 32'h30) and undefined instruction = 10 (Cause 32'h28).
REQ-014 SHALL, in RUN with exl=1 and exc_valid=1: update Cause only, hold EPC, and enter REDIRECT.
REQ-015 SHALL assert pc_redirect=1 with redirect_pc=EXC_VECTOR for exactly one cycle in REDIRECT, then return to RUN.
REQ-016 SHALL, in RUN with exl=1, eret=1 and exc_valid=0: clear exl and enter RETURN.
REQ-017 SHALL assert pc_redirect=1 with redirect_pc=EPC for exactly one cycle in RETURN, then return to RUN.
REQ-018 SHALL ignore exc_valid and eret while in REDIRECT or RETURN, since that is the flush cycle of the same event.
REQ-019 SHALL treat eret with exl=0 as a no-op.
REQ-020 SHALL give exc_valid priority when exc_valid and eret are high in the same cycle; eret is dropped.
REQ-021 SHALL map register addresses as Status=12 (bit1 EXL, bit0 IE; other bits read 0), Cause=13 and EPC=14; Cause is read-only.
REQ-022 SHALL apply mtc0 writes at the next edge.
REQ-023 SHALL, when a hardware exception update collides with an mtc0 write to the same register, apply the hardware update and drop the write.
REQ-024 SHALL return 0 on mfc0_data for unmapped addresses.
REQ-025 SHALL drive exl as the Status.EXL bit; redirect_pc SHALL be 0 when pc_redirect=0.

Reset
REQ-026 SHALL, with reset=0 at an edge: clear EPC, Cause and Status to 0, set state to RUN, and drive pc_redirect=0 and redirect_pc=0.
REQ-027 SHALL give reset priority over all inputs, including mid-REDIRECT and mid-RETURN; no redirect pulse SHALL follow reset.

Configuration
REQ-028 SHALL, with CP0_EXC_COUNT_EN defined, provide a 32-bit exception counter at address 22 that increments on each REDIRECT entry, wraps 32'hFFFF_FFFF to 0, is writable by mtc0, and resets to 0.
REQ-029 SHALL, without CP0_EXC_COUNT_EN, omit the counter and read 0 at address 22.

Structure
REQ-030 SHALL place the register address constants, ExcCode constants, state encoding and default vector in shared package cp0_pkg.
REQ-031 SHALL implement the counter as sub-module cp0_exc_counter, instantiated only under CP0_EXC_COUNT_EN.

Verification
REQ-032 SHALL cover: overflow with exc_epc=32'h0040_0010 -> next cycle pc_redirect=1, redirect_pc=32'h8000_0180, EPC=32'h0040_0010, Cause=32'h30, exl=1.
REQ-033 SHALL cover: undefined instruction, then eret 3 cycles later -> RETURN pulse with redirect_pc=32'h0040_0010, exl=0 afterwards.
REQ-034 SHALL cover: a second exception with exl=1 and exc_epc=32'h0040_0100 -> EPC unchanged, Cause updated, redirect to the vector.
REQ-035 SHALL cover: exc_valid and eret in the same cycle in HANDLER -> vector redirect, exl stays 1; exc_valid held high 2 cycles -> single pulse.
REQ-036 SHALL cover: reset=0 during REDIRECT -> all outputs 0 next cycle, mfc0 of 12/13/14 reads 0.
REQ-037 SHALL cover, with CP0_EXC_COUNT_EN: mtc0 22<=32'hFFFF_FFFF, one exception -> counter reads 0.
